// File: rtl/dru_pkg.sv
// Shared definitions for the DRU load controller: FSM state encoding and word size.
package dru_pkg;

  localparam int DRU_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_LO   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_RD_UP   = 3'd3,
    ST_WAIT_UP = 3'd4,
    ST_COMMIT  = 3'd5,
    ST_ERR     = 3'd6
  } dru_state_e;

endpackage

// File: rtl/dru_ldctrl_wdog.sv
// Wait-state watchdog: counts consecutive wait cycles, restarting from zero on every
// entry into a wait state, and flags the cycle in which the limit is reached.
module dru_ldctrl_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter, held at zero outside the wait states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (in_wait) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  assign expired = in_wait && (cnt_r == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dru_load_ctrl.sv
// Sequences a 64-bit load as two aligned 32-bit memory reads and commits the pair to a
// reg64 slot. Define DRU_LDCTRL_TIMEOUT_EN to enable the wait-state timeout and err pulse.
module dru_load_ctrl
  import dru_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_dst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  output logic              lo_reg32_enable,
  output logic              up_reg32_enable,
  output logic              reg64_enable1,
  output logic              reg64_enable2,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DRU_WORD_BYTES - 1);

  dru_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              dst_r;
  logic              ready_r;
  logic              rd_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              en1_r;
  logic              en2_r;
  logic              done_r;
  logic              in_wait_s;
  logic              timeout_s;
  logic [ADDR_W-1:0] up_addr_s;

  assign in_wait_s = (state_r == ST_WAIT_LO) || (state_r == ST_WAIT_UP);
  // Upper word address wraps naturally at 2^ADDR_W
  assign up_addr_s = (addr_r & ALIGN_MASK) + ADDR_W'(DRU_WORD_BYTES);

`ifdef DRU_LDCTRL_TIMEOUT_EN
  logic err_r;

  dru_ldctrl_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .in_wait(in_wait_s),
    .expired(timeout_s)
  );

  // err pulses during the ERR state, i.e. one cycle after an unanswered wait expires
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= in_wait_s && !mem_rd_valid && timeout_s;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Load sequencer FSM with registered strobes, address and commit pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      dst_r      <= 1'b0;
      ready_r    <= 1'b1;
      rd_en_r    <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      en1_r      <= 1'b0;
      en2_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      en1_r   <= 1'b0;
      en2_r   <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            addr_r     <= req_addr;
            dst_r      <= req_dst;
            mem_addr_r <= req_addr & ALIGN_MASK;
            rd_en_r    <= 1'b1;
            ready_r    <= 1'b0;
            state_r    <= ST_RD_LO;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_RD_LO: state_r <= ST_WAIT_LO;
        ST_WAIT_LO: begin
          if (mem_rd_valid) begin
            mem_addr_r <= up_addr_s;
            rd_en_r    <= 1'b1;
            state_r    <= ST_RD_UP;
          end else if (timeout_s) begin
            state_r <= ST_ERR;
          end else begin
            state_r <= ST_WAIT_LO;
          end
        end
        ST_RD_UP: state_r <= ST_WAIT_UP;
        ST_WAIT_UP: begin
          if (mem_rd_valid) begin
            en1_r   <= !dst_r;
            en2_r   <= dst_r;
            done_r  <= 1'b1;
            state_r <= ST_COMMIT;
          end else if (timeout_s) begin
            state_r <= ST_ERR;
          end else begin
            state_r <= ST_WAIT_UP;
          end
        end
        ST_COMMIT, ST_ERR: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = ready_r;
  assign mem_rd_en       = rd_en_r;
  assign mem_addr        = mem_addr_r;
  assign lo_reg32_enable = (state_r == ST_WAIT_LO) && mem_rd_valid;
  assign up_reg32_enable = (state_r == ST_WAIT_UP) && mem_rd_valid;
  assign reg64_enable1   = en1_r;
  assign reg64_enable2   = en2_r;
  assign done            = done_r;

endmodule

// File: tb/tb_dru_load_ctrl.sv
// Self-checking bench for dru_load_ctrl: directed scenarios plus randomized loads checked
// against a cycle-arithmetic reference model of the load sequence.
module tb_dru_load_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        req_dst = 1'b0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_valid = 1'b0;
  logic        lo_reg32_enable, up_reg32_enable;
  logic        reg64_enable1, reg64_enable2;
  logic        done, err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] q_addr[$];
  bit          q_dst[$];
  int          q_dlo[$];
  int          q_dup[$];

  always #5 sys_clk = ~sys_clk;

  dru_load_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_dst(req_dst),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
    .lo_reg32_enable(lo_reg32_enable), .up_reg32_enable(up_reg32_enable),
    .reg64_enable1(reg64_enable1), .reg64_enable2(reg64_enable2),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] a, input bit d, input int dlo, input int dup);
    q_addr.push_back(a);
    q_dst.push_back(d);
    q_dlo.push_back(dlo);
    q_dup.push_back(dup);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_lo"}, lo_reg32_enable, 32'd0);
    chk({tag, "_up"}, up_reg32_enable, 32'd0);
    chk({tag, "_en1"}, reg64_enable1, 32'd0);
    chk({tag, "_en2"}, reg64_enable2, 32'd0);
    chk({tag, "_done"}, done, 32'd0);
  endtask

  // Model: a load accepted in cycle A strobes at A+1 and A+dlo+2, and completes at A+dlo+dup+3,
  // where dlo/dup are the memory response delays (cycles after each strobe).
  task automatic run_seq();
    int n = q_addr.size();
    int idx = 0;
    bit act = 1'b0;
    bit dst = 1'b0;
    int s1 = 0, s2 = 0, dc = 0, dlo = 0, dup = 0;
    int budget = 20;
    int start = cyc;
    bit due, win, strobe;
    logic [31:0] lo_a = 32'd0, up_a = 32'd0;
    foreach (q_dlo[i]) budget += q_dlo[i] + q_dup[i] + 4;
    while (idx < n || act) begin
      if (cyc - start > budget) begin
        chk("cycle_budget", 32'd1, 32'd0);
        break;
      end
      tick();
      req_valid = (idx < n);
      if (idx < n) begin
        req_addr = q_addr[idx];
        req_dst  = q_dst[idx];
      end
      due = act && (cyc == s1 + dlo || cyc == s2 + dup);
      win = act && ((cyc > s1 && cyc <= s1 + dlo) || (cyc > s2 && cyc <= s2 + dup));
      mem_rd_valid = due || (!win && ($urandom_range(0, 3) == 0));
      @(negedge sys_clk);
      chk("req_ready", req_ready, !act);
      if (req_valid && !act) begin
        act  = 1'b1;
        dst  = q_dst[idx];
        dlo  = q_dlo[idx];
        dup  = q_dup[idx];
        lo_a = q_addr[idx] & 32'hFFFF_FFFC;
        up_a = lo_a + 32'd4;
        s1   = cyc + 1;
        s2   = cyc + dlo + 2;
        dc   = cyc + dlo + dup + 3;
        idx++;
      end
      strobe = act && (cyc == s1 || cyc == s2);
      chk("mem_rd_en", mem_rd_en, strobe);
      if (strobe) chk("mem_addr", mem_addr, (cyc == s1) ? lo_a : up_a);
      chk("lo_en", lo_reg32_enable, act && mem_rd_valid && cyc == s1 + dlo);
      chk("up_en", up_reg32_enable, act && mem_rd_valid && cyc == s2 + dup);
      chk("reg64_en1", reg64_enable1, act && cyc == dc && !dst);
      chk("reg64_en2", reg64_enable2, act && cyc == dc && dst);
      chk("done", done, act && cyc == dc);
      chk("err", err, 32'd0);
      chk("enable_onehot",
          ($countones({lo_reg32_enable, up_reg32_enable, reg64_enable1, reg64_enable2}) <= 1),
          32'd1);
      if (act && cyc == dc) act = 1'b0;
    end
    req_valid = 1'b0;
    mem_rd_valid = 1'b0;
    q_addr.delete();
    q_dst.delete();
    q_dlo.delete();
    q_dup.delete();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", req_ready, 32'd1);
    chk("rst_rd_en", mem_rd_en, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", err, 32'd0);
    chk_quiet("rst");
    sys_rst_n = 1'b1;

    // Nominal, unaligned wrap, stalled memory
    push(32'h0000_0100, 1'b0, 1, 1);
    run_seq();
    push(32'hFFFF_FFFE, 1'b1, 1, 1);
    run_seq();
    push(32'h0000_2468, 1'b0, 7, 7);
    run_seq();

    // Back-to-back with req_valid held high
    push(32'h0000_1000, 1'b1, 1, 2);
    push(32'h0000_1007, 1'b0, 2, 1);
    run_seq();

    // Reset during WAIT_UP
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0200;
    req_dst   = 1'b0;
    @(negedge sys_clk);
    chk("mid_accept_ready", req_ready, 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge sys_clk);
    chk("mid_lo_addr", mem_addr, 32'h0000_0200);
    tick();
    mem_rd_valid = 1'b1;
    @(negedge sys_clk);
    chk("mid_lo_en", lo_reg32_enable, 32'd1);
    tick();
    mem_rd_valid = 1'b0;
    @(negedge sys_clk);
    chk("mid_up_addr", mem_addr, 32'h0000_0204);
    tick();
    @(negedge sys_clk);
    chk("mid_wait_ready", req_ready, 32'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 32'd1);
    chk("mid_rst_rd_en", mem_rd_en, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk_quiet("mid_rst");
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_quiet("mid_rst_hold");
    #2;
    sys_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_rd_valid = 1'b1;
      @(negedge sys_clk);
      chk_quiet("stray_valid");
      chk("stray_ready", req_ready, 32'd1);
      chk("stray_rd_en", mem_rd_en, 32'd0);
    end
    mem_rd_valid = 1'b0;

`ifdef DRU_LDCTRL_TIMEOUT_EN
    // Timeout with no memory response (TIMEOUT_CYC = 8)
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_dst   = 1'b1;
    @(negedge sys_clk);
    chk("to_accept", req_ready, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      req_valid = 1'b0;
      @(negedge sys_clk);
      chk("to_err", err, (k == 10));
      chk("to_rd_en", mem_rd_en, (k == 1));
      chk("to_ready", req_ready, (k >= 11));
      chk_quiet("to");
    end
    push(32'h0000_0080, 1'b1, 1, 1);
    run_seq();
`endif

    // Randomized loads
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) begin
        push($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 7), $urandom_range(1, 7));
      end
      run_seq();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dru_load_ctrl.md
DRU_LOAD_CTRL -- requirements
Module: dru_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, wait-cycle limit used only when DRU_LDCTRL_TIMEOUT_EN is defined.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  64-bit load request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  byte address of the 64-bit operand.
- req_dst  in  1  target register: 0 = reg64 slot 1, 1 = reg64 slot 2.
- mem_rd_en  out  1  one-cycle memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd_valid  in  1  mem_data valid this cycle; mem_data goes straight to the data register unit.
- lo_reg32_enable  out  1  load mem_data into the lower 32-bit register.
- up_reg32_enable  out  1  load mem_data into the upper 32-bit register.
- reg64_enable1  out  1  commit the {up,lo} pair to 64-bit register 1.
- reg64_enable2  out  1  commit the {up,lo} pair to 64-bit register 2.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse (tied 0 when the macro is undefined).

Function
REQ-005 SHALL implement the FSM states IDLE, RD_LO, WAIT_LO, RD_UP, WAIT_UP, COMMIT and ERR.
REQ-006 SHALL assert req_ready only in IDLE; on acceptance it SHALL latch req_addr and req_dst and move to RD_LO.
REQ-007 SHALL, in RD_LO, assert mem_rd_en for exactly one cycle with mem_addr = {addr[ADDR_W-1:2],2'b00}, then move to WAIT_LO.
REQ-008 SHALL, in WAIT_LO, drive lo_reg32_enable = mem_rd_valid combinationally and move to RD_UP on mem_rd_valid; otherwise it holds.
REQ-009 SHALL, in RD_UP, assert mem_rd_en for one cycle with mem_addr = aligned addr + 4, modulo 2^ADDR_W (wraps to 0), then move to WAIT_UP.
REQ-010 SHALL, in WAIT_UP, drive up_reg32_enable = mem_rd_valid and move to COMMIT on mem_rd_valid.
REQ-011 SHALL, in COMMIT, assert reg64_enable1 (dst 0) or reg64_enable2 (dst 1) together with done for one cycle, then return to IDLE.
REQ-012 SHALL ignore mem_rd_valid in IDLE, RD_LO, RD_UP, COMMIT and ERR; no enable asserts in those states.
REQ-013 SHALL give minimum latency, with mem_rd_valid one cycle after each mem_rd_en, of done 5 cycles after the accepting edge; back-to-back requests are accepted the cycle after done.
REQ-014 SHALL never assert more than one of the four register enables in the same cycle.
REQ-015 SHALL ignore req_valid outside IDLE; the latched fields are not altered mid-operation.

Reset
REQ-016 SHALL, while sys_rst_n is low, force state IDLE, latched addr/dst = 0, mem_addr = 0 and all enables, mem_rd_en, done and err = 0; req_ready = 1.
REQ-017 SHALL abandon an in-flight transaction when reset asserts mid-operation, with no reg64 enable and no done; a late mem_rd_valid after release is ignored.

Configuration
REQ-018 SHALL, with DRU_LDCTRL_TIMEOUT_EN defined, count cycles in WAIT_LO/WAIT_UP (cleared on entry); reaching TIMEOUT_CYC without mem_rd_valid moves to ERR, which pulses err for one cycle, asserts no reg64 enable and no done, then returns to IDLE.
REQ-019 SHALL, without DRU_LDCTRL_TIMEOUT_EN, wait indefinitely; err is constant 0 and no counter logic exists.

Structure
REQ-020 SHALL place the FSM state enum and the constant DRU_WORD_BYTES = 4 in shared package dru_pkg.
REQ-021 SHALL implement the timeout counter as sub-module dru_ldctrl_wdog, instantiated only under DRU_LDCTRL_TIMEOUT_EN.

Verification
REQ-022 SHALL cover these scenarios:
- Nominal load: addr=0x100, dst=0, valid 1 cycle after each strobe -> mem_addr 0x100 then 0x104; lo, up, reg64_enable1 each high 1 cycle; done 5 cycles after accept.
- Unaligned/wrap: addr=0xFFFFFFFE, dst=1 -> mem_addr 0xFFFFFFFC then 0x00000000; reg64_enable2 and done pulse.
- Stalled memory: valid delayed 7 cycles per word -> enables coincide only with valid; done 17 cycles after accept; req_ready low throughout.
- Reset mid-operation: sys_rst_n low during WAIT_UP -> all outputs 0, req_ready 1, no done; stray mem_rd_valid afterwards produces no enable.
- Timeout (macro defined, TIMEOUT_CYC=8): no mem_rd_valid -> err pulses 1 cycle after 8 wait cycles, no reg64 enable; next request completes normally.
- Back-to-back: req_valid held high for two requests -> second accepted the cycle after the first done; enables never overlap.
